prog_clk_div: RTL and testbench

//  Programmable synchronous clock divider: successor to the fixed divide-by-4 FSM divider.

---
 rtl/clk_div_pkg.sv | 28 ++
 rtl/clk_div_phase_cnt.sv | 37 +++
 rtl/prog_clk_div.sv | 104 ++++++++++
 tb/tb_prog_clk_div.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
// Holds the FSM state encoding, the minimum ratio and the clamp/duty helper functions.
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [31:0] MIN_RATIO = 32'd2;

    // Ratios of 0 and 1 cannot form a period with a high and a low phase, so they run as 2.
    function automatic logic [31:0] clamp_ratio(input logic [31:0] ratio);
        return (ratio < MIN_RATIO) ? MIN_RATIO : ratio;
    endfunction

    // Pulse mode is high only in phase 0; duty mode is high for the first ceil(N/2) phases.
    function automatic logic duty_high(input logic [31:0] phase,
                                       input logic [31:0] ratio,
                                       input logic        mode);
        if (mode)
            return (phase < ((ratio + 32'd1) >> 1));
        else
            return (phase == 32'd0);
    endfunction

endpackage

// File: rtl/clk_div_phase_cnt.sv
// Phase counter for the clock divider: counts 0..ratio_q-1 and wraps.
// next_phase is exposed so the parent can register its outputs one cycle early.
module clk_div_phase_cnt
    import clk_div_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] ratio_q,
    output logic [CNT_W-1:0] phase,
    output logic [CNT_W-1:0] next_phase,
    output logic             last
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    assign last = (phase == (ratio_q - ONE));

    always_comb begin
        next_phase = phase;
        if (clear)
            next_phase = '0;
        else if (enable)
            next_phase = last ? '0 : (phase + ONE);
    end

    always_ff @(posedge clk) begin
        if (rst)
            phase <= '0;
        else
            phase <= next_phase;
    end

endmodule

// File: rtl/prog_clk_div.sv
// Programmable synchronous clock divider with pulse / ~50% duty modes and a period tick.
// Ratio and mode are shadowed and only refreshed on the edge that enters phase 0.
module prog_clk_div
    import clk_div_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter bit DEF_MODE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div_ratio,
    input  logic             mode,
    output logic             clk_out,
    output logic             tick,
    output logic             active
);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] phase;
    logic [CNT_W-1:0] next_phase;
    logic [CNT_W-1:0] ratio_q;
    logic [CNT_W-1:0] next_ratio;
    logic             mode_q;
    logic             next_mode;
    logic             last;
    logic             load;
    logic             cnt_clear;
    logic             cnt_en;

    // load marks every transition into phase 0 of a running period
    always_comb begin
        next_state = state;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    next_state = RUN;
                    load       = 1'b1;
                end
            end
            RUN: begin
                if (last) begin
                    if (en)
                        load = 1'b1;
                    else
                        next_state = IDLE;
                end else if (!en) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (en) begin
                    next_state = RUN;
                    if (last)
                        load = 1'b1;
                end else if (last) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase

        cnt_clear  = (next_state == IDLE);
        cnt_en     = (state != IDLE);
        next_ratio = load ? CNT_W'(clamp_ratio(32'(div_ratio))) : ratio_q;
        next_mode  = load ? mode : mode_q;
    end

    clk_div_phase_cnt #(
        .CNT_W (CNT_W)
    ) u_phase_cnt (
        .clk        (clk),
        .rst        (rst),
        .clear      (cnt_clear),
        .enable     (cnt_en),
        .ratio_q    (ratio_q),
        .phase      (phase),
        .next_phase (next_phase),
        .last       (last)
    );

    // Outputs are evaluated from the upcoming phase so they line up with it once registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ratio_q <= CNT_W'(MIN_RATIO);
            mode_q  <= DEF_MODE;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            state   <= next_state;
            ratio_q <= next_ratio;
            mode_q  <= next_mode;
            tick    <= (next_state != IDLE) && (next_phase == '0);
            clk_out <= (next_state != IDLE) &&
                       duty_high(32'(next_phase), 32'(next_ratio), next_mode);
        end
    end

    assign active = (state != IDLE);

endmodule

// File: tb/tb_prog_clk_div.sv
// Self-checking bench for prog_clk_div against a period-level behavioural model.
// Each scenario task drives stimulus and compares {clk_out, tick, active} inline.
module tb_prog_clk_div;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [7:0] div_ratio = 8'd4;
    logic       mode = 1'b0;
    logic       clk_out;
    logic       tick;
    logic       active;

    int checks = 0;
    int fails  = 0;

    // model: running flag, position in period, latched period length and mode
    int m_on    = 0;
    int m_phase = 0;
    int m_n     = 2;
    int m_mode  = 0;
    logic [2:0] exp_v;

    prog_clk_div #(
        .CNT_W    (8),
        .DEF_MODE (1'b0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .div_ratio (div_ratio),
        .mode      (mode),
        .clk_out   (clk_out),
        .tick      (tick),
        .active    (active)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] model_outputs();
        logic hi;
        if (m_on == 0) return 3'b000;
        if (m_mode != 0) hi = (m_phase < (m_n + 1) / 2);
        else             hi = (m_phase == 0);
        return {hi, (m_phase == 0), 1'b1};
    endfunction

    // One clock: advance the model with the inputs seen at this edge, then settle.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            m_on = 0; m_phase = 0; m_n = 2; m_mode = 0;
        end else if (m_on == 0) begin
            if (en) begin
                m_on = 1; m_phase = 0;
                m_n = (int'(div_ratio) < 2) ? 2 : int'(div_ratio);
                m_mode = int'(mode);
            end
        end else if (m_phase == m_n - 1) begin
            m_phase = 0;
            if (en) begin
                m_n = (int'(div_ratio) < 2) ? 2 : int'(div_ratio);
                m_mode = int'(mode);
            end else begin
                m_on = 0;
            end
        end else begin
            m_phase = m_phase + 1;
        end
        #1;
        exp_v = model_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; div_ratio = 8'd4; mode = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({clk_out, tick, active} !== 3'b000) begin
                fails++;
                $display("[TB] FAIL reset_hold cyc%0d: got %b expected 000", i, {clk_out, tick, active});
            end
        end
        rst = 1'b0;
        step();
        checks++;
        if ({clk_out, tick, active} !== 3'b111) begin
            fails++;
            $display("[TB] FAIL reset_release: got %b expected 111", {clk_out, tick, active});
        end
    endtask

    task automatic test_pulse_mode();
        do_reset();
        en = 1'b1; div_ratio = 8'd4; mode = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            checks++;
            if ({clk_out, tick, active} !== exp_v) begin
                fails++;
                $display("[TB] FAIL pulse_n4 cyc%0d: got %b expected %b", i, {clk_out, tick, active}, exp_v);
            end
        end
    endtask

    task automatic test_duty_mode();
        do_reset();
        en = 1'b1; div_ratio = 8'd5; mode = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i == 10) div_ratio = 8'd4;
            if (i == 21) div_ratio = 8'd3;
            step();
            checks++;
            if ({clk_out, tick, active} !== exp_v) begin
                fails++;
                $display("[TB] FAIL duty cyc%0d: got %b expected %b", i, {clk_out, tick, active}, exp_v);
            end
        end
    endtask

    task automatic test_ratio_change();
        int guard;
        do_reset();
        en = 1'b1; div_ratio = 8'd6; mode = 1'b0;
        step();
        guard = 0;
        while (m_phase != 2 && guard < 20) begin
            step();
            guard++;
        end
        checks++;
        if (guard >= 20) begin
            fails++;
            $display("[TB] FAIL ratio_change_wait: got timeout expected phase 2");
        end
        div_ratio = 8'd3;
        for (int i = 0; i < 24; i++) begin
            if (i == 8) mode = 1'b1;
            step();
            checks++;
            if ({clk_out, tick, active} !== exp_v) begin
                fails++;
                $display("[TB] FAIL ratio_change cyc%0d: got %b expected %b", i, {clk_out, tick, active}, exp_v);
            end
        end
    endtask

    task automatic test_clamp();
        int last_tick;
        for (int r = 0; r < 2; r++) begin
            do_reset();
            en = 1'b1; div_ratio = 8'(r); mode = 1'(r);
            for (int i = 0; i < 8; i++) begin
                step();
                checks++;
                if ({clk_out, tick, active} !== exp_v) begin
                    fails++;
                    $display("[TB] FAIL clamp_r%0d cyc%0d: got %b expected %b", r, i, {clk_out, tick, active}, exp_v);
                end
            end
        end
        do_reset();
        en = 1'b1; div_ratio = 8'd255; mode = 1'b1;
        last_tick = -1;
        for (int i = 0; i < 520; i++) begin
            step();
            if (tick === 1'b1) begin
                if (last_tick >= 0) begin
                    checks++;
                    if (i - last_tick != 255) begin
                        fails++;
                        $display("[TB] FAIL period_255: got %0d expected 255", i - last_tick);
                    end
                end
                last_tick = i;
            end
            checks++;
            if ({clk_out, tick, active} !== exp_v) begin
                fails++;
                $display("[TB] FAIL n255 cyc%0d: got %b expected %b", i, {clk_out, tick, active}, exp_v);
            end
        end
    endtask

    task automatic test_drain();
        do_reset();
        en = 1'b1; div_ratio = 8'd8; mode = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (m_on != 0 && m_phase == 3 && i < 10) en = 1'b0;
            if (i == 14) en = 1'b1;
            if (i > 14 && m_phase == 3 && i < 24) en = 1'b0;
            if (i > 14 && m_phase == 5) en = 1'b1;
            step();
            checks++;
            if ({clk_out, tick, active} !== exp_v) begin
                fails++;
                $display("[TB] FAIL drain cyc%0d: got %b expected %b", i, {clk_out, tick, active}, exp_v);
            end
        end
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({clk_out, tick, active} !== 3'b000) begin
            fails++;
            $display("[TB] FAIL rst_mid_period: got %b expected 000", {clk_out, tick, active});
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 9) == 0) en = ~en;
            if ($urandom_range(0, 5) == 0) div_ratio = 8'($urandom_range(0, 12));
            if ($urandom_range(0, 7) == 0) mode = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 199) == 0);
            step();
            checks++;
            if ({clk_out, tick, active} !== exp_v) begin
                fails++;
                $display("[TB] FAIL random cyc%0d: got %b expected %b", i, {clk_out, tick, active}, exp_v);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_pulse_mode();
        test_duty_mode();
        test_ratio_change();
        test_clamp();
        test_drain();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
